// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit, stop bit.
// The bit time comes from the run-time byte_rate word, latched when a frame is accepted.
module uart_tx_frame #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        tx_start,
    input  logic [7:0]  tx_data,
    input  logic [31:0] byte_rate,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_t;

    state_t      r_state, w_state;
    logic        r_tx, w_tx;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic [31:0] r_timer, w_timer;
    logic [2:0]  r_cnt, w_cnt;
    logic [7:0]  r_shift, w_shift;
    logic        r_par, w_par;
    logic [31:0] r_rate, w_rate;

    logic [31:0] w_rate_clamped;
    logic        w_tc;

    // Rates below 2 would leave no room for the timer to count; treat them as 2.
    assign w_rate_clamped = (byte_rate < 32'd2) ? 32'd2 : byte_rate;
    assign w_tc           = (r_timer == (r_rate - 32'd1));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= StIdle;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_timer <= '0;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_rate  <= 32'd2;
        end else begin
            r_state <= w_state;
            r_tx    <= w_tx;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_timer <= w_timer;
            r_cnt   <= w_cnt;
            r_shift <= w_shift;
            r_par   <= w_par;
            r_rate  <= w_rate;
        end
    end

    always_comb begin
        w_state = r_state;
        w_tx    = r_tx;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_timer = r_timer + 32'd1;
        w_cnt   = r_cnt;
        w_shift = r_shift;
        w_par   = r_par;
        w_rate  = r_rate;

        unique case (r_state)
            StIdle: begin
                w_timer = '0;
                if (tx_start) begin
                    w_state = StStart;
                    w_shift = tx_data;
                    w_par   = (^tx_data) ^ PARITY_ODD;
                    w_rate  = w_rate_clamped;
                    w_cnt   = '0;
                    w_tx    = 1'b0;
                    w_busy  = 1'b1;
                end
            end
            StStart: begin
                if (w_tc) begin
                    w_timer = '0;
                    w_state = StData;
                    w_tx    = r_shift[0];
                    w_shift = r_shift >> 1;
                end
            end
            StData: begin
                if (w_tc) begin
                    w_timer = '0;
                    if (r_cnt == 3'd7) begin
                        w_cnt = '0;
                        if (PARITY_EN) begin
                            w_state = StParity;
                            w_tx    = r_par;
                        end else begin
                            w_state = StStop;
                            w_tx    = 1'b1;
                        end
                    end else begin
                        w_cnt   = r_cnt + 3'd1;
                        w_tx    = r_shift[0];
                        w_shift = r_shift >> 1;
                    end
                end
            end
            StParity: begin
                if (w_tc) begin
                    w_timer = '0;
                    w_state = StStop;
                    w_tx    = 1'b1;
                end
            end
            StStop: begin
                if (w_tc) begin
                    w_timer = '0;
                    w_state = StIdle;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                end
            end
            default: begin
                w_state = StIdle;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_timer = '0;
            end
        endcase
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

endmodule
